add_sub_arbiter: RTL

- Shares one combinational add_sub unit (W-bit add/subtract with carry/borrow flag) among N requesters.
- Round-robin arbitration with valid/ready handshake on each request port.
- Results go into a single registered response slot, tagged with the requester ID.
- Sits between the requesting datapath engines and the shared add_sub instance.

---
 rtl/add_sub_pkg.sv | 32 +++
 rtl/add_sub.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/add_sub_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add_sub arbiter slice: default width, slot states,
// an ID-width helper and a reference add/sub function for benches.
package add_sub_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Requester ID width; a single requester still needs one bit of ID.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reference result as {ovf, sum}: carry out for add, borrow (a < b) for subtract.
    function automatic logic [W_DEFAULT:0] golden_add_sub(
        input logic [W_DEFAULT-1:0] a,
        input logic [W_DEFAULT-1:0] b,
        input logic                 sub
    );
        logic [W_DEFAULT:0] res;
        if (sub) begin
            res = {(a < b), a - b};
        end else begin
            res = {1'b0, a} + {1'b0, b};
        end
        return res;
    endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational W-bit adder/subtractor with carry (add) or borrow (sub) flag.
module add_sub #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    // Subtract is a + ~b + 1; its carry out is the inverse of the borrow.
    assign raw = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    assign sum = raw[W-1:0];
    assign ovf = raw[W] ^ sub;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from last_grant+1, wrapping modulo N.
module rr_arbiter
    import add_sub_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic           enable,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDW'((int'(last_grant) + off) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one add_sub unit among N requesters with round-robin arbitration and
// a single registered response slot tagged with the requester ID.
module add_sub_arbiter
    import add_sub_pkg::*;
#(
    parameter  int W   = W_DEFAULT,
    parameter  int N   = 4,
    localparam int IDW = idw(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_sub,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_sum,
    output logic           rsp_ovf
);

    slot_state_t    state;
    logic [IDW-1:0] last_grant;
    logic           slot_free;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_sub;
    logic [W-1:0]   au_sum;
    logic           au_ovf;

    // The slot can take a new result when empty or when it drains this cycle.
    assign slot_free = (state == SLOT_EMPTY) || rsp_ready;
    assign req_ready = grant;
    assign accept    = |grant;
    assign rsp_valid = (state == SLOT_FULL);

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req        (req_valid),
        .enable     (slot_free && !rst),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_sub = req_sub[i];
            end
        end
    end

    add_sub #(
        .W (W)
    ) u_add_sub (
        .a   (sel_a),
        .b   (sel_b),
        .sub (sel_sub),
        .sum (au_sum),
        .ovf (au_ovf)
    );

    // Slot FSM: a refill wins over a drain, so back-to-back accepts keep it FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SLOT_EMPTY;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_ovf    <= 1'b0;
            last_grant <= IDW'(N - 1);
        end else begin
            case (state)
                SLOT_EMPTY, SLOT_FULL: begin
                    if (accept) begin
                        state      <= SLOT_FULL;
                        rsp_id     <= grant_idx;
                        rsp_sum    <= au_sum;
                        rsp_ovf    <= au_ovf;
                        last_grant <= grant_idx;
                    end else if (slot_free) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule
